// File: rtl/necir_transmitter.sv
// NEC IR transmitter: leader, addr, ~addr, cmd, ~cmd (LSB first), stop mark, trailing gap; or a repeat code.
// Envelope and carrier-gated LED drive are registered together, so ir_out never leads or lags ir_env.
`timescale 1ns/1ps
module necir_transmitter #(
  parameter int UNIT_CYCLES    = 56250,
  parameter int CARRIER_PERIOD = 2632,
  parameter int CARRIER_HIGH   = 877,
  parameter int GAP_UNITS      = 72
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       repeat_req,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       ir_env,
  output logic       ir_out
);

  localparam int UCW = $clog2(UNIT_CYCLES + 1);
  localparam int CCW = $clog2(CARRIER_PERIOD + 1);
  localparam int UNW = $clog2(((GAP_UNITS > 16) ? GAP_UNITS : 16) + 1);
  localparam logic [UCW-1:0] UC_LAST = UCW'(UNIT_CYCLES - 1);
  localparam logic [CCW-1:0] CC_LAST = CCW'(CARRIER_PERIOD - 1);
  localparam logic [CCW-1:0] CC_HIGH = CCW'(CARRIER_HIGH);
  localparam logic MARK_START_HIGH = (CARRIER_HIGH > 0);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
  } state_t;

  state_t         state;
  state_t         seg_next;
  logic [UCW-1:0] unit_cnt;
  logic [UNW-1:0] unit_num;
  logic [UNW-1:0] seg_units;
  logic [CCW-1:0] car_cnt;
  logic [CCW-1:0] car_inc;
  logic [4:0]     bit_cnt;
  logic [31:0]    shreg;
  logic           rep;
  logic           seg_end;
  logic           next_mark;

  // Length (in units) of the current segment and the segment that follows it.
  always_comb begin
    seg_units = UNW'(1);
    seg_next  = IDLE;
    case (state)
      LEAD_MARK: begin
        seg_units = UNW'(16);
        seg_next  = LEAD_SPACE;
      end
      LEAD_SPACE: begin
        seg_units = rep ? UNW'(4) : UNW'(8);
        seg_next  = rep ? STOP_MARK : BIT_MARK;
      end
      BIT_MARK:  seg_next = BIT_SPACE;
      BIT_SPACE: begin
        seg_units = shreg[0] ? UNW'(3) : UNW'(1);
        seg_next  = (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
      end
      STOP_MARK: seg_next = (GAP_UNITS == 0) ? IDLE : GAP;
      GAP: begin
        seg_units = UNW'(GAP_UNITS);
        seg_next  = IDLE;
      end
      default: ;
    endcase
    seg_end   = (state != IDLE) && (unit_cnt == UC_LAST) && (unit_num == seg_units - UNW'(1));
    next_mark = (seg_next == LEAD_MARK) || (seg_next == BIT_MARK) || (seg_next == STOP_MARK);
    car_inc   = (car_cnt == CC_LAST) ? '0 : car_cnt + CCW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ir_env   <= 1'b0;
      ir_out   <= 1'b0;
      unit_cnt <= '0;
      unit_num <= '0;
      car_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rep      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start || repeat_req) begin
          state    <= LEAD_MARK;
          busy     <= 1'b1;
          ir_env   <= 1'b1;
          ir_out   <= MARK_START_HIGH;
          unit_cnt <= '0;
          unit_num <= '0;
          car_cnt  <= '0;
          bit_cnt  <= '0;
          if (start) begin
            shreg <= {~cmd, cmd, ~addr, addr};
            rep   <= 1'b0;
          end else begin
            rep <= 1'b1;
          end
        end
      end else begin
        if (unit_cnt == UC_LAST) begin
          unit_cnt <= '0;
          unit_num <= seg_end ? '0 : unit_num + UNW'(1);
        end else begin
          unit_cnt <= unit_cnt + UCW'(1);
        end

        if (seg_end) begin
          state  <= seg_next;
          ir_env <= next_mark;
          // Every mark restarts the carrier so it opens on a high phase.
          if (next_mark) begin
            car_cnt <= '0;
            ir_out  <= MARK_START_HIGH;
          end else begin
            car_cnt <= car_inc;
            ir_out  <= 1'b0;
          end
          if (state == BIT_SPACE) begin
            shreg   <= {1'b0, shreg[31:1]};
            bit_cnt <= bit_cnt + 5'd1;
          end
          if (seg_next == IDLE) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            car_cnt <= '0;
          end
        end else begin
          car_cnt <= car_inc;
          ir_out  <= ir_env & (car_inc < CC_HIGH);
        end
      end
    end
  end

endmodule
